// File: rtl/lsu_store_queue.sv
// Store queue between the LSU and the data bus: holds speculative stores until commit,
// drains committed stores in order, and forwards buffered bytes to younger loads.
module lsu_store_queue #(
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    localparam int unsigned BE = DATA_WIDTH / 8,
    localparam int unsigned PW = $clog2(DEPTH),
    localparam int unsigned CW = PW + 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  enq_valid,
    output logic                  enq_ready,
    input  logic [ADDR_WIDTH-1:0] enq_paddr,
    input  logic [DATA_WIDTH-1:0] enq_wrdata,
    input  logic [BE-1:0]         enq_byteenable,
    input  logic                  enq_uncached,
    input  logic                  commit_valid,
    input  logic [ADDR_WIDTH-1:0] ld_paddr,
    input  logic [BE-1:0]         ld_byteenable,
    output logic                  fwd_hit,
    output logic [DATA_WIDTH-1:0] fwd_data,
    output logic                  fwd_stall,
    output logic                  dbus_request,
    output logic [ADDR_WIDTH-1:0] dbus_paddr,
    output logic [DATA_WIDTH-1:0] dbus_wrdata,
    output logic [BE-1:0]         dbus_byteenable,
    output logic                  dbus_uncached,
    input  logic                  dbus_ready,
    output logic [CW-1:0]         count,
    output logic                  empty
);

    logic [PW-1:0] head_q, head_d, cmt_q, cmt_d, tail_q, tail_d;
    // Occupancy counters disambiguate the equal-pointer cases (full vs empty, all committed vs none).
    logic [CW-1:0] count_q, count_d, ncmt_q, ncmt_d;

    logic [ADDR_WIDTH-1:0] paddr_mem [DEPTH];
    logic [DATA_WIDTH-1:0] data_mem  [DEPTH];
    logic [BE-1:0]         be_mem    [DEPTH];
    logic                  unc_mem   [DEPTH];

    logic enq_fire, cmt_fire, drain_fire;

    assign enq_ready    = (count_q < CW'(DEPTH));
    assign empty        = (count_q == '0);
    assign count        = count_q;
    assign dbus_request = (ncmt_q != '0);

    assign dbus_paddr      = paddr_mem[head_q];
    assign dbus_wrdata     = data_mem[head_q];
    assign dbus_byteenable = be_mem[head_q];
    assign dbus_uncached   = unc_mem[head_q];

    always_comb begin
        enq_fire   = enq_valid && enq_ready && !flush;
        cmt_fire   = commit_valid && (count_q != ncmt_q);
        drain_fire = dbus_request && dbus_ready;
        head_d     = head_q + PW'(drain_fire);
        cmt_d      = cmt_q + PW'(cmt_fire);
        ncmt_d     = ncmt_q + CW'(cmt_fire) - CW'(drain_fire);
        // Flush rolls tail back to the post-commit boundary; only committed entries survive.
        if (flush) begin
            tail_d  = cmt_d;
            count_d = ncmt_d;
        end else begin
            tail_d  = tail_q + PW'(enq_fire);
            count_d = count_q + CW'(enq_fire) - CW'(drain_fire);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            cmt_q   <= '0;
            tail_q  <= '0;
            count_q <= '0;
            ncmt_q  <= '0;
        end else begin
            head_q  <= head_d;
            cmt_q   <= cmt_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            ncmt_q  <= ncmt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (enq_fire) begin
            paddr_mem[tail_q] <= enq_paddr;
            data_mem[tail_q]  <= enq_wrdata;
            be_mem[tail_q]    <= enq_byteenable;
            unc_mem[tail_q]   <= enq_uncached;
        end
    end

    logic [PW-1:0]         slot;
    logic [BE-1:0]         lane_sup, cov;
    logic [DATA_WIDTH-1:0] merged;
    logic                  unc_hit;
    logic                  ld_lo_unused;

    assign ld_lo_unused = ^ld_paddr[1:0];

    // Walk oldest to youngest so a younger matching byte overwrites an older one.
    always_comb begin
        slot     = '0;
        lane_sup = '0;
        merged   = '0;
        unc_hit  = 1'b0;
        cov      = '0;
        fwd_data = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            slot = head_q + PW'(i);
            if ((CW'(i) < count_q) &&
                (paddr_mem[slot][ADDR_WIDTH-1:2] == ld_paddr[ADDR_WIDTH-1:2])) begin
                if (unc_mem[slot]) begin
                    unc_hit = 1'b1;
                end
                for (int b = 0; b < int'(BE); b++) begin
                    if (be_mem[slot][b]) begin
                        lane_sup[b]      = 1'b1;
                        merged[b*8 +: 8] = data_mem[slot][b*8 +: 8];
                    end
                end
            end
        end
        cov = lane_sup & ld_byteenable;
        for (int b = 0; b < int'(BE); b++) begin
            fwd_data[b*8 +: 8] = cov[b] ? merged[b*8 +: 8] : 8'h00;
        end
        fwd_hit   = (cov == ld_byteenable) && (ld_byteenable != '0) && !unc_hit;
        fwd_stall = ((cov != '0) && (cov != ld_byteenable)) || unc_hit;
    end

endmodule
